axim_wr_ctrl: RTL
=================

AXIM_WR_CTRL -- requirements
Module: axim_wr_ctrl

Interface
REQ-001 C_M_AXI_ADDR_WIDTH, 32, AXI address width.
REQ-002 C_M_AXI_DATA_WIDTH, 32, AXI/stream data width; fixed at 32 in this revision.
REQ-003 C_XFER_SIZE_WIDTH, 32, transfer byte-count width.
REQ-004 C_MAX_BURST_LEN, 16, maximum beats per AXI burst; power of two, 2..256.
REQ-005 clk  in  1  clock; all logic on rising edge.
REQ-006 rstn  in  1  reset, asynchronous, active-high.
REQ-007 ctrl_wstart_i  in  1  single-cycle request to start a transfer.
REQ-008 ctrl_waddr_offset_i  in  ADDR  start byte address; bits [1:0] are ignored and treated as 0.
REQ-009 ctrl_wxfer_size_i  in  XFER  transfer length in bytes.
REQ-010 ctrl_wdone_o  out  1  single-cycle pulse when the transfer completes.
REQ-011 ctrl_werr_o  out  1  sticky flag: a non-OKAY BRESP was received; cleared on the next accepted start.
REQ-012 wr_tdata_i / wr_tvalid_i / wr_tready_o  in/in/out  32/1/1  write data stream from mem_subsys.
REQ-013 m_axi_awaddr/awlen/awsize/awburst/awvalid/awready  out×5/in  ADDR/8/3/2/1/1  AXI4 AW channel.
REQ-014 m_axi_wdata/wstrb/wlast/wvalid/wready  out×4/in  32/4/1/1/1  AXI4 W channel.
REQ-015 m_axi_bresp/bvalid/bready  in/in/out  2/1/1  AXI4 B channel.

Function
REQ-016 FSM states: IDLE, AW, W, B, DONE.
REQ-017 IDLE: ctrl_wstart_i=1 latches the address and the size, and sets word count = ceil(size/4).
  - count>0 -> AW.
  - count=0 -> DONE.
REQ-018 ctrl_wstart_i outside IDLE is ignored and shall not alter the transfer in progress.
REQ-019 Burst beats = min(remaining words, C_MAX_BURST_LEN, (4096 - addr[11:0])/4). A burst shall never cross a 4 KB boundary.
REQ-020 AW: m_axi_awvalid=1 from the cycle after start, or after the previous burst's B handshake.
  - awlen = beats-1, awsize = 3'b010, awburst = INCR (2'b01).
  - All AW signals are held stable until awready; AW->W on the handshake.
REQ-021 W: wvalid = wr_tvalid_i, wr_tready_o = m_axi_wready, wdata = wr_tdata_i; purely combinational pass-through, zero added latency.
REQ-022 wlast = 1 on the final beat of each burst. After the wlast handshake -> B. wr_tready_o = 0 in every state except W.
REQ-023 wstrb = 4'hF, except on the final beat of the transfer when size%4≠0: wstrb = (1<<(size%4))-1.
REQ-024 B: bready=1. On the bvalid handshake:
  - bresp≠2'b00 sets ctrl_werr_o.
  - Address advances by beats*4 and remaining words decrease by beats.
  - remaining=0 -> DONE, else -> AW.
REQ-025 DONE: ctrl_wdone_o=1 for exactly one cycle, then -> IDLE.
  - Minimum latency: last B handshake at cycle N -> done at N+1.
  - Zero-size transfer: start at cycle 0 -> done at cycle 1.
REQ-026 Exactly one burst is outstanding at a time; AW of burst k+1 is not issued before B of burst k.
REQ-027 The transfer completes on write responses, not on write data; an error response does not abort the transfer.

Reset
REQ-028 rstn=1 asynchronously forces the following, including mid-transfer (the in-flight transfer is abandoned, no done pulse):
  - state = IDLE;
  - awvalid, wvalid, wlast, bready, wr_tready_o, ctrl_wdone_o, ctrl_werr_o = 0;
  - address and counters = 0.
REQ-029 After rstn deasserts, the first ctrl_wstart_i is accepted no earlier than the next rising edge.

Structure
REQ-030 Package axim_pkg holds:
  - the FSM state enum;
  - AXI_BURST_INCR = 2'b01, AXI_SIZE_4B = 3'b010, AXI_RESP_OKAY = 2'b00;
  - AXI_4K_BYTES = 4096.
REQ-031 One sub-module, axim_burst_calc: combinational beat-count computation from address, remaining words and C_MAX_BURST_LEN.

Verification
REQ-032 addr 0x40000000, size 256, awready/wready/bvalid always 1:
  - 4 bursts of awlen=15 at 0x40000000, +0x40, +0x80, +0xC0;
  - 64 wlast-terminated beats total; one done pulse.
REQ-033 addr 0x40000FF0, size 64:
  - burst 1 is awlen=3 at 0x40000FF0;
  - burst 2 is awlen=11 at 0x40001000.
REQ-034 size 6: one burst, awlen=1, wstrb 4'hF then 4'h3, wlast on beat 2.
REQ-035 size 0: done at cycle 1 after start, no AW/W/B activity; random wready/tvalid/awready with size 128: data order preserved, exactly 32 beats.
REQ-036 bresp=2'b10 on burst 2 of 4: all 4 bursts complete, done pulses, ctrl_werr_o=1 until the next start; rstn asserted mid-W: all valids 0 on the same cycle, no done pulse.

Source files
------------

// File: rtl/axim_pkg.sv
// Shared types and AXI encodings for the AXI4 write-master controller.
package axim_pkg;

    // Write-controller FSM states
    typedef enum logic [2:0] {
        StIdle,
        StAw,
        StW,
        StB,
        StDone
    } wr_state_e;

    localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
    localparam logic [2:0]  AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
    localparam int unsigned AXI_4K_BYTES   = 4096;

endpackage

// File: rtl/axim_burst_calc.sv
// Beat count for the next burst: min(remaining words, max burst, words left in the 4 KB page).
module axim_burst_calc
    import axim_pkg::*;
#(
    parameter int unsigned C_XFER_SIZE_WIDTH = 32,
    parameter int unsigned C_MAX_BURST_LEN   = 16
) (
    input  logic [9:0]                         i_word_off,
    input  logic [C_XFER_SIZE_WIDTH-1:0]       i_remaining,
    output logic [$clog2(C_MAX_BURST_LEN):0]   o_beats
);

    localparam int unsigned BeatW = $clog2(C_MAX_BURST_LEN) + 1;

    logic [10:0]                  w_words_to_4k;
    logic [C_XFER_SIZE_WIDTH-1:0] w_lim;

    // Word offset within the page is aligned, so this ranges 1..1024
    assign w_words_to_4k = 11'(AXI_4K_BYTES / 4) - {1'b0, i_word_off};

    // Take the smallest of the three limits
    always_comb begin
        w_lim = C_XFER_SIZE_WIDTH'(C_MAX_BURST_LEN);
        if (C_XFER_SIZE_WIDTH'(w_words_to_4k) < w_lim) begin
            w_lim = C_XFER_SIZE_WIDTH'(w_words_to_4k);
        end
        if (i_remaining < w_lim) begin
            w_lim = i_remaining;
        end
        o_beats = w_lim[BeatW-1:0];
    end

endmodule

// File: rtl/axim_wr_ctrl.sv
// AXI4 write master: splits a byte-count transfer into 4 KB-safe INCR bursts, one outstanding.
module axim_wr_ctrl
    import axim_pkg::*;
#(
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
    parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_XFER_SIZE_WIDTH  = 32,
    parameter int unsigned C_MAX_BURST_LEN    = 16
) (
    input  logic                              clk,
    input  logic                              rstn,

    input  logic                              ctrl_wstart_i,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     ctrl_waddr_offset_i,
    input  logic [C_XFER_SIZE_WIDTH-1:0]      ctrl_wxfer_size_i,
    output logic                              ctrl_wdone_o,
    output logic                              ctrl_werr_o,

    input  logic [C_M_AXI_DATA_WIDTH-1:0]     wr_tdata_i,
    input  logic                              wr_tvalid_i,
    output logic                              wr_tready_o,

    output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic [7:0]                        m_axi_awlen,
    output logic [2:0]                        m_axi_awsize,
    output logic [1:0]                        m_axi_awburst,
    output logic                              m_axi_awvalid,
    input  logic                              m_axi_awready,

    output logic [C_M_AXI_DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                              m_axi_wlast,
    output logic                              m_axi_wvalid,
    input  logic                              m_axi_wready,

    input  logic [1:0]                        m_axi_bresp,
    input  logic                              m_axi_bvalid,
    output logic                              m_axi_bready
);

    localparam int unsigned BeatW = $clog2(C_MAX_BURST_LEN) + 1;
    localparam int unsigned StrbW = C_M_AXI_DATA_WIDTH / 8;

    wr_state_e                      r_state;
    logic [C_M_AXI_ADDR_WIDTH-1:0]  r_addr;
    logic [C_XFER_SIZE_WIDTH-1:0]   r_remaining;
    logic [1:0]                     r_tail;
    logic [BeatW-1:0]               r_beat_cnt;
    logic                           r_awvalid;
    logic                           r_bready;
    logic                           r_done;
    logic                           r_err;

    logic [BeatW-1:0]               w_beats;
    logic [BeatW-1:0]               w_beats_m1;
    logic [C_XFER_SIZE_WIDTH-1:0]   w_words;
    logic                           w_in_w;
    logic                           w_w_hs;
    logic                           w_xfer_last;
    logic [3:0]                     w_tail_mask;

    // Words in the transfer, rounding a partial trailing word up
    assign w_words = (ctrl_wxfer_size_i >> 2)
                   + C_XFER_SIZE_WIDTH'(|ctrl_wxfer_size_i[1:0]);

    axim_burst_calc #(
        .C_XFER_SIZE_WIDTH (C_XFER_SIZE_WIDTH),
        .C_MAX_BURST_LEN   (C_MAX_BURST_LEN)
    ) u_burst_calc (
        .i_word_off  (r_addr[11:2]),
        .i_remaining (r_remaining),
        .o_beats     (w_beats)
    );

    // Address and remaining count only change on a B handshake, so beats is stable per burst
    assign w_beats_m1    = w_beats - BeatW'(1);
    assign m_axi_awaddr  = r_addr;
    assign m_axi_awlen   = 8'(w_beats_m1);
    assign m_axi_awsize  = AXI_SIZE_4B;
    assign m_axi_awburst = AXI_BURST_INCR;
    assign m_axi_awvalid = r_awvalid;

    // Stream is passed straight through to the W channel while a burst is open
    assign w_in_w       = (r_state == StW);
    assign m_axi_wvalid = w_in_w & wr_tvalid_i;
    assign wr_tready_o  = w_in_w & m_axi_wready;
    assign m_axi_wdata  = wr_tdata_i;
    assign m_axi_wlast  = w_in_w && (r_beat_cnt == BeatW'(1));
    assign w_w_hs       = m_axi_wvalid & m_axi_wready;

    // Final beat of the whole transfer: last beat of the burst that drains the count
    assign w_xfer_last  = m_axi_wlast && (r_remaining == C_XFER_SIZE_WIDTH'(w_beats));
    assign w_tail_mask  = (4'b0001 << r_tail) - 4'b0001;
    assign m_axi_wstrb  = (w_xfer_last && (r_tail != 2'b00)) ? StrbW'(w_tail_mask) : '1;

    assign m_axi_bready = r_bready;
    assign ctrl_wdone_o = r_done;
    assign ctrl_werr_o  = r_err;

    // Transfer sequencing: IDLE -> (AW -> W -> B)* -> DONE -> IDLE
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            r_state     <= StIdle;
            r_addr      <= '0;
            r_remaining <= '0;
            r_tail      <= '0;
            r_beat_cnt  <= '0;
            r_awvalid   <= 1'b0;
            r_bready    <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (ctrl_wstart_i) begin
                        r_err       <= 1'b0;
                        r_addr      <= ctrl_waddr_offset_i & ~C_M_AXI_ADDR_WIDTH'(3);
                        r_remaining <= w_words;
                        r_tail      <= ctrl_wxfer_size_i[1:0];
                        if (w_words != '0) begin
                            r_state   <= StAw;
                            r_awvalid <= 1'b1;
                        end else begin
                            r_state <= StDone;
                            r_done  <= 1'b1;
                        end
                    end
                end
                StAw: begin
                    if (m_axi_awready) begin
                        r_awvalid  <= 1'b0;
                        r_beat_cnt <= w_beats;
                        r_state    <= StW;
                    end
                end
                StW: begin
                    if (w_w_hs) begin
                        if (r_beat_cnt == BeatW'(1)) begin
                            r_state  <= StB;
                            r_bready <= 1'b1;
                        end else begin
                            r_beat_cnt <= r_beat_cnt - BeatW'(1);
                        end
                    end
                end
                StB: begin
                    if (m_axi_bvalid) begin
                        r_bready    <= 1'b0;
                        if (m_axi_bresp != AXI_RESP_OKAY) begin
                            r_err <= 1'b1;
                        end
                        r_addr      <= r_addr + C_M_AXI_ADDR_WIDTH'({w_beats, 2'b00});
                        r_remaining <= r_remaining - C_XFER_SIZE_WIDTH'(w_beats);
                        if (r_remaining == C_XFER_SIZE_WIDTH'(w_beats)) begin
                            r_state <= StDone;
                            r_done  <= 1'b1;
                        end else begin
                            r_state   <= StAw;
                            r_awvalid <= 1'b1;
                        end
                    end
                end
                StDone: begin
                    r_done  <= 1'b0;
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

endmodule
